// File: rtl/host_mem_lat_if.sv
// OBI request/response channel bundles shared by host_mem_lat and its masters.
interface obi_req_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;

  modport slave  (input req, we, be, addr, wdata, output gnt);
  modport master (output req, we, be, addr, wdata, input gnt);
endinterface

interface obi_rsp_if;
  logic        rvalid;
  logic [31:0] rdata;

  modport slave  (output rvalid, rdata);
  modport master (input rvalid, rdata);
endinterface

// File: rtl/host_mem_lat.sv
// Word-addressed host memory with fixed LATENCY response pipeline on an OBI slave port.
// Define HOST_MEM_LAT_STALL_EN to refuse grants pseudo-randomly from a 16-bit LFSR.
module host_mem_lat #(
  parameter int unsigned MEM_SIZE_WORD = 32'h00008000,
  parameter int          LATENCY       = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  obi_req_if.slave    host_mem_req,
  obi_rsp_if.slave    host_mem_rsp,
  output logic [31:0] rd_cnt_o,
  output logic [31:0] wr_cnt_o
);
  localparam int unsigned AW = (MEM_SIZE_WORD > 1) ? $clog2(MEM_SIZE_WORD) : 1;

  logic [31:0] mem_array [MEM_SIZE_WORD];

  logic                    stall;
  logic                    accept;
  logic [29:0]             idx;
  logic                    in_range;
  logic [AW-1:0]           widx;
  logic [3:0]              lane_we;
  logic [31:0]             rsp_data_d;
  logic [LATENCY-1:0]      valid_q;
  logic [LATENCY-1:0][31:0] data_q;
  logic [31:0]             rd_cnt_q, rd_cnt_d;
  logic [31:0]             wr_cnt_q, wr_cnt_d;
  logic                    unused_addr_lsb;

  assign unused_addr_lsb = ^host_mem_req.addr[1:0];

  assign idx      = host_mem_req.addr[31:2];
  assign in_range = {2'b00, idx} < MEM_SIZE_WORD;
  assign widx     = idx[AW-1:0];

  // Grant is held low during reset so no access can slip in before the pipeline is cleared.
  assign host_mem_req.gnt = host_mem_req.req & ~stall & rst_ni;
  assign accept           = host_mem_req.req & host_mem_req.gnt;

`ifdef HOST_MEM_LAT_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  assign stall  = lfsr_q[0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign stall = 1'b0;
`endif

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_we[gi] = accept & host_mem_req.we & in_range & host_mem_req.be[gi];
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < 4; k++) begin
      if (lane_we[k]) begin
        mem_array[widx][8*k +: 8] <= host_mem_req.wdata[8*k +: 8];
      end
    end
  end

  // Read data is taken before this edge's write lands; writes respond with zero.
  always_comb begin
    rsp_data_d = 32'h0;
    if (!host_mem_req.we) begin
      rsp_data_d = in_range ? mem_array[widx] : 32'hDEADBEEF;
    end
  end

  // Data only moves behind a valid so rdata holds the last response between beats.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q[0] <= accept;
      if (accept) begin
        data_q[0] <= rsp_data_d;
      end
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign host_mem_rsp.rvalid = valid_q[LATENCY-1];
  assign host_mem_rsp.rdata  = data_q[LATENCY-1];

  assign rd_cnt_d = (accept && !host_mem_req.we) ? rd_cnt_q + 32'd1 : rd_cnt_q;
  assign wr_cnt_d = (accept &&  host_mem_req.we) ? wr_cnt_q + 32'd1 : wr_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_cnt_q <= 32'h0;
      wr_cnt_q <= 32'h0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;
endmodule

// File: tb/tb_host_mem_lat.sv
// Bench for host_mem_lat: LATENCY=2 and LATENCY=3 instances driven in lockstep against a queue model.
module tb_host_mem_lat;
  localparam int unsigned MEM = 32'h00008000;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        req   = 1'b0;
  logic        we    = 1'b0;
  logic [3:0]  be    = 4'h0;
  logic [31:0] addr  = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rc2, wc2, rc3, wc3;

  always #5 clk = ~clk;

  obi_req_if req2_if ();
  obi_rsp_if rsp2_if ();
  obi_req_if req3_if ();
  obi_rsp_if rsp3_if ();

  assign req2_if.req = req;   assign req3_if.req = req;
  assign req2_if.we = we;     assign req3_if.we = we;
  assign req2_if.be = be;     assign req3_if.be = be;
  assign req2_if.addr = addr; assign req3_if.addr = addr;
  assign req2_if.wdata = wdata; assign req3_if.wdata = wdata;

  host_mem_lat #(.MEM_SIZE_WORD(MEM), .LATENCY(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .host_mem_req(req2_if), .host_mem_rsp(rsp2_if),
    .rd_cnt_o(rc2), .wr_cnt_o(wc2));

  host_mem_lat #(.MEM_SIZE_WORD(MEM), .LATENCY(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .host_mem_req(req3_if), .host_mem_rsp(rsp3_if),
    .rd_cnt_o(rc3), .wr_cnt_o(wc3));

  int n_pass  = 0;
  int n_total = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // ---------------- model: responses as (due edge, data) queues ----------------
  typedef struct { int due; logic [31:0] data; } rsp_t;
  rsp_t        q2[$], q3[$];
  logic [31:0] mmem [int unsigned];
  logic [31:0] m_rd = 0, m_wr = 0;
  logic [31:0] last2 = 0, last3 = 0;
  logic [15:0] lfsr_m = 16'hACE1;
  int          cyc = 0;
  int          m_acc = 0;
  bit          chk_en = 0;

  function automatic logic stall_now();
`ifdef HOST_MEM_LAT_STALL_EN
    return lfsr_m[0];
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge rst_n) begin
    q2.delete(); q3.delete();
    m_rd = 0; m_wr = 0; last2 = 0; last3 = 0;
    lfsr_m = 16'hACE1;
  end

  always @(posedge clk) begin : mdl
    int unsigned idx;
    logic [31:0] d, w;
    logic        fb;
    if (rst_n) begin
      cyc++;
      if (req && !stall_now()) begin
        idx = addr >> 2;
        d = 32'h0;
        if (we) begin
          m_wr++;
          if (idx < MEM) begin
            w = mmem.exists(idx) ? mmem[idx] : 32'hx;
            for (int k = 0; k < 4; k++) if (be[k]) w[8*k +: 8] = wdata[8*k +: 8];
            mmem[idx] = w;
          end
        end else begin
          m_rd++;
          if (idx >= MEM) d = 32'hDEADBEEF;
          else d = mmem.exists(idx) ? mmem[idx] : 32'hx;
        end
        q2.push_back('{cyc + 1, d});
        q3.push_back('{cyc + 2, d});
        m_acc++;
      end
      fb = ^(lfsr_m & 16'h002D);
      lfsr_m = (lfsr_m >> 1) | (16'(fb) << 15);
    end
  end

  always @(negedge clk) begin : cmp
    logic ev, eg;
    if (chk_en) begin
      eg = req & rst_n & ~stall_now();
      ev = 1'b0;
      if (q2.size() > 0 && q2[0].due == cyc) begin ev = 1'b1; last2 = q2[0].data; void'(q2.pop_front()); end
      chk("l2_rvalid", 32'(rsp2_if.rvalid), 32'(ev));
      chk("l2_rdata", rsp2_if.rdata, last2);
      chk("l2_gnt", 32'(req2_if.gnt), 32'(eg));
      chk("l2_rd_cnt", rc2, m_rd);
      chk("l2_wr_cnt", wc2, m_wr);
      ev = 1'b0;
      if (q3.size() > 0 && q3[0].due == cyc) begin ev = 1'b1; last3 = q3[0].data; void'(q3.pop_front()); end
      chk("l3_rvalid", 32'(rsp3_if.rvalid), 32'(ev));
      chk("l3_rdata", rsp3_if.rdata, last3);
      chk("l3_gnt", 32'(req3_if.gnt), 32'(eg));
      chk("l3_rd_cnt", rc3, m_rd);
      chk("l3_wr_cnt", wc3, m_wr);
    end
  end

  // ---------------- response capture and stimulus helpers ----------------
  logic [31:0] cap2[$], cap3[$];

  always @(negedge clk) begin
    if (rsp2_if.rvalid) cap2.push_back(rsp2_if.rdata);
    if (rsp3_if.rvalid) cap3.push_back(rsp3_if.rdata);
  end

  task automatic issue(input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    req = 1'b1; we = w; be = b; addr = a; wdata = d;
    @(negedge clk);
    while (!req2_if.gnt && n < 64) begin n++; @(negedge clk); end
    if (n >= 64) chk("gnt_timeout", 32'(n), 32'd0);
    @(posedge clk); #2;
    $display("req we=%0b be=%h addr=%h wdata=%h accepted at edge %0d", w, b, a, d, cyc);
  endtask

  task automatic wait_rsp(input int want);
    int n = 0;
    while ((cap2.size() < want || cap3.size() < want) && n < 40) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 40) chk("rsp_timeout", 32'(cap3.size()), 32'(want));
    @(posedge clk); #2;
  endtask

  task automatic xfer(input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] r2, output logic [31:0] r3);
    cap2.delete(); cap3.delete();
    issue(w, b, a, d);
    req = 1'b0;
    wait_rsp(1);
    r2 = (cap2.size() > 0) ? cap2[0] : 32'hx;
    r3 = (cap3.size() > 0) ? cap3[0] : 32'hx;
    $display("rsp addr=%h l2=%h l3=%h", a, r2, r3);
  endtask

  task automatic preload(input int unsigned idx, input logic [31:0] v);
    u_dut2.mem_array[idx] = v;
    u_dut3.mem_array[idx] = v;
    mmem[idx] = v;
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stim
    logic [31:0] r2, r3, b_rd, b_wr;
    int acc0, granted, refused, guard, ir;

    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    for (int i = 0; i < 8; i++) preload(i, 32'hA0A00000 + 32'(i));
    preload(32'h40, 32'h11223344);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b1;

    @(negedge clk); #1;
    chk("idle_rvalid", 32'(rsp2_if.rvalid | rsp3_if.rvalid), 32'd0);
    chk("idle_rd_cnt", rc2, 32'd0);
    chk("idle_wr_cnt", wc3, 32'd0);
    chk("idle_gnt", 32'(req2_if.gnt | req3_if.gnt), 32'd0);
    @(posedge clk); #2;

    xfer(1'b1, 4'hF, 32'h00010000, 32'hCAFEF00D, r2, r3);
    chk("wr_rsp_zero", r2 | r3, 32'h0);
    xfer(1'b0, 4'hF, 32'h00010000, 32'h0, r2, r3);
    chk("raw_l2", r2, 32'hCAFEF00D);
    chk("raw_l3", r3, 32'hCAFEF00D);
    chk("cnt_rd_1", rc2, 32'd1);
    chk("cnt_wr_1", wc2, 32'd1);

    xfer(1'b1, 4'b0101, 32'h00000100, 32'hAABBCCDD, r2, r3);
    xfer(1'b0, 4'hF, 32'h00000100, 32'h0, r2, r3);
    chk("be_l2", r2, 32'h11BB33DD);
    chk("be_l3", r3, 32'h11BB33DD);

    // write immediately followed by a read of the same word
    cap2.delete(); cap3.delete();
    issue(1'b1, 4'hF, 32'h00010004, 32'h5A5A1234);
    issue(1'b0, 4'hF, 32'h00010006, 32'h0);
    req = 1'b0;
    wait_rsp(2);
    chk("raw_b2b_l3", (cap3.size() > 1) ? cap3[1] : 32'hx, 32'h5A5A1234);

    cap2.delete(); cap3.delete();
    for (int i = 0; i < 4; i++) issue(1'b0, 4'hF, 32'(4 * i), 32'h0);
    req = 1'b0;
    wait_rsp(4);
    for (int i = 0; i < 4; i++) begin
      chk("b2b_l3", (cap3.size() > i) ? cap3[i] : 32'hx, 32'hA0A00000 + 32'(i));
      chk("b2b_l2", (cap2.size() > i) ? cap2[i] : 32'hx, 32'hA0A00000 + 32'(i));
    end

    b_rd = rc2; b_wr = wc2;
    xfer(1'b0, 4'hF, MEM * 4, 32'h0, r2, r3);
    chk("oor_rd_l2", r2, 32'hDEADBEEF);
    chk("oor_rd_l3", r3, 32'hDEADBEEF);
    xfer(1'b1, 4'hF, MEM * 4, 32'h12345678, r2, r3);
    chk("oor_rd_inc", rc2 - b_rd, 32'd1);
    chk("oor_wr_inc", wc2 - b_wr, 32'd1);
    chk("oor_mem0_l2", u_dut2.mem_array[0], 32'hA0A00000);
    chk("oor_mem0_l3", u_dut3.mem_array[0], 32'hA0A00000);

    acc0 = m_acc; granted = 0; refused = 0; guard = 0;
    cap2.delete(); cap3.delete();
    while (granted < 100 && guard < 800) begin
      guard++;
      ir    = $urandom_range(0, 8);
      req   = ($urandom_range(0, 3) != 0);
      we    = $urandom_range(0, 1) != 0;
      be    = 4'($urandom_range(0, 15));
      wdata = $urandom;
      addr  = (ir == 8) ? MEM * 4 : 32'(ir * 4 + $urandom_range(0, 3));
      @(negedge clk);
      if (req) begin
        if (req2_if.gnt) granted++;
        else refused++;
      end
      @(posedge clk); #2;
    end
    req = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    $display("random: granted=%0d refused=%0d rsp_l2=%0d rsp_l3=%0d", granted, refused, cap2.size(), cap3.size());
    chk("rand_grants", 32'(granted), 32'(m_acc - acc0));
    chk("rand_rsp_l2", 32'(cap2.size()), 32'(m_acc - acc0));
    chk("rand_rsp_l3", 32'(cap3.size()), 32'(m_acc - acc0));
`ifdef HOST_MEM_LAT_STALL_EN
    chk("stall_seen", 32'(refused > 0), 32'd1);
`else
    chk("no_stall", 32'(refused), 32'd0);
`endif

    issue(1'b0, 4'hF, 32'h4, 32'h0);
    issue(1'b0, 4'hF, 32'h8, 32'h0);
    rst_n = 1'b0;
    cap2.delete(); cap3.delete();
    repeat (3) @(posedge clk);
    #2;
    req = 1'b0;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #2;
    chk("rst_flush_l2", 32'(cap2.size()), 32'd0);
    chk("rst_flush_l3", 32'(cap3.size()), 32'd0);
    chk("rst_cnt_rd", rc3, 32'd0);
    xfer(1'b0, 4'hF, 32'h00010000, 32'h0, r2, r3);
    chk("rst_mem_l2", r2, 32'hCAFEF00D);
    chk("rst_mem_l3", r3, 32'hCAFEF00D);
    xfer(1'b0, 4'hF, 32'h00000100, 32'h0, r2, r3);
    chk("rst_mem_be", r3, 32'h11BB33DD);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
